// File: rtl/calc_value.sv
// -----------------------------------------------------------------------------
// calc_value
//
// Purpose:
//   Scales full_scale by a percentage with half-up rounding:
//     value = (percent * full_scale + 50) / 100
//   A small sequential datapath does the work in two phases:
//     - an 8-cycle shift-add multiply, followed by one cycle that adds the
//       rounding bias of 50;
//     - a restoring divide by 100 that produces one quotient bit per cycle.
//   The latency from the capture edge to the edge that raises done is fixed
//   at NUM_W+17 cycles and never depends on the operand values.
//
// Configuration:
//   CALC_VALUE_CLAMP_EN - when defined, a captured percent above 100 is
//                         replaced by 100, so value never exceeds full_scale.
//                         When undefined, percent is used as-is (0..255).
//                         Timing and handshake are the same in both builds.
//
// Ports:
//   clk         in   1        rising-edge clock
//   reset       in   1        asynchronous active-low reset
//   start       in   1        capture request, honoured in IDLE or DONE
//   percent     in   8        ratio in percent
//   full_scale  in   NUM_W    value corresponding to 100 percent
//   busy        out  1        computation in progress
//   done        out  1        value holds a valid result
//   value       out  NUM_W+2  rounded scaled result
// -----------------------------------------------------------------------------
module calc_value #(
  parameter int NUM_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       percent,
  input  logic [NUM_W-1:0] full_scale,
  output logic             busy,
  output logic             done,
  output logic [NUM_W+1:0] value
);

  // Product / dividend width: 255 * (2^NUM_W - 1) + 50 fits in NUM_W+8 bits.
  localparam int PROD_W = NUM_W + 8;
  // The counter has to reach PROD_W-1 in DIV and 8 in MULT.
  localparam int CNT_W  = $clog2(PROD_W);

  localparam logic [CNT_W-1:0]  MULT_LAST  = CNT_W'(8);
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(PROD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [PROD_W-1:0] ROUND_BIAS = PROD_W'(50);
  localparam logic [7:0]        DIVISOR    = 8'd100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_reg;
  logic [7:0]         pct_reg;    // captured (possibly clamped) percent
  logic [NUM_W-1:0]   fs_reg;     // captured full_scale
  logic [PROD_W-1:0]  acc_reg;    // product, then dividend/quotient
  logic [6:0]         rem_reg;    // division remainder, always < 100
  logic [CNT_W-1:0]   count_reg;  // step counter within MULT or DIV

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time
  // ---------------------------------------------------------------------------
  logic [7:0] pct_capture;

`ifdef CALC_VALUE_CLAMP_EN
  assign pct_capture = (percent > 8'd100) ? 8'd100 : percent;
`else
  assign pct_capture = percent;
`endif

  // ---------------------------------------------------------------------------
  // Multiply step: add full_scale shifted by the current bit position when
  // that bit of percent is set. The operands themselves are never shifted, so
  // the captured values stay intact for the whole computation.
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] partial_next;

  always_comb begin
    partial_next = '0;
    if (pct_reg[count_reg[2:0]]) begin
      partial_next = {8'd0, fs_reg} << count_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divide step: the dividend MSB shifts into the remainder, the
  // divisor is subtracted when it fits, and the quotient bit shifts into the
  // vacated LSB of acc_reg. After PROD_W steps acc_reg holds the quotient.
  // ---------------------------------------------------------------------------
  logic [7:0]        rem_shift;
  logic              q_bit;
  logic [6:0]        rem_next;
  logic [PROD_W-1:0] acc_shift;

  always_comb begin
    rem_shift = {rem_reg, acc_reg[PROD_W-1]};
    q_bit     = (rem_shift >= DIVISOR);
    rem_next  = q_bit ? 7'(rem_shift - DIVISOR) : rem_shift[6:0];
    acc_shift = {acc_reg[PROD_W-2:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pct_reg   <= '0;
      fs_reg    <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // value is left untouched so the previous result stays readable
          // until the new one loads.
          if (start) begin
            pct_reg   <= pct_capture;
            fs_reg    <= full_scale;
            acc_reg   <= '0;
            rem_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state_reg <= MULT;
          end
        end

        MULT: begin
          if (count_reg == MULT_LAST) begin
            // Ninth cycle: fold in the half-up rounding bias.
            acc_reg   <= acc_reg + ROUND_BIAS;
            count_reg <= '0;
            state_reg <= DIV;
          end else begin
            acc_reg   <= acc_reg + partial_next;
            count_reg <= count_reg + CNT_ONE;
          end
        end

        DIV: begin
          acc_reg <= acc_shift;
          rem_reg <= rem_next;
          if (count_reg == DIV_LAST) begin
            // The quotient never needs more than NUM_W+2 bits.
            value     <= acc_shift[NUM_W+1:0];
            done      <= 1'b1;
            busy      <= 1'b0;
            count_reg <= '0;
            state_reg <= DONE;
          end else begin
            count_reg <= count_reg + CNT_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_value.sv
// -----------------------------------------------------------------------------
// tb_calc_value
//
// Self-checking bench for calc_value (NUM_W = 19). Applies a table of directed
// vectors, a set of random vectors compared against an arithmetic reference
// model, and hand-written sequences for the handshake, restart and reset
// corner cases. Honours CALC_VALUE_CLAMP_EN in its expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_value;

  localparam int NUM_W   = 19;
  localparam int LATENCY = NUM_W + 17;
  localparam int TIMEOUT = 200;

  logic             clk;
  logic             reset;
  logic             start;
  logic [7:0]       percent;
  logic [NUM_W-1:0] full_scale;
  logic             busy;
  logic             done;
  logic [NUM_W+1:0] value;

  calc_value #(.NUM_W(NUM_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .percent    (percent),
    .full_scale (full_scale),
    .busy       (busy),
    .done       (done),
    .value      (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the specified formula.
  function automatic longint model(input int p, input longint fs);
    longint pe;
    pe = p;
`ifdef CALC_VALUE_CLAMP_EN
    if (pe > 100) pe = 100;
`endif
    return (pe * fs + 64'sd50) / 100;
  endfunction

  // Waits (bounded) for done after a capture edge; lat = edges after capture.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction: pulse start, check handshake, wait for the result.
  task automatic do_calc(input logic [7:0] p, input logic [NUM_W-1:0] fs,
                         output logic [NUM_W+1:0] got, output int lat);
    @(negedge clk);
    start = 1'b1; percent = p; full_scale = fs;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_capture", busy, 1);
    check("done_after_capture", done, 0);
    wait_done(lat);
    got = value;
    check("busy_at_done", busy, 0);
    $display("txn percent=%0d full_scale=%0d -> value=%0d latency=%0d", p, fs, got, lat);
  endtask

  typedef struct {
    logic [7:0]       p;
    logic [NUM_W-1:0] fs;
    logic [NUM_W+1:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [NUM_W+1:0] got;
    int lat;
    int rises;
    int first_rise;
    logic prev_done;

    // Directed vectors with hand-derived expectations.
    vecs[0]  = '{8'd50,  19'd1000,   21'd500};
    vecs[1]  = '{8'd33,  19'd10,     21'd3};
    vecs[2]  = '{8'd1,   19'd49,     21'd0};
    vecs[3]  = '{8'd1,   19'd50,     21'd1};
    vecs[4]  = '{8'd100, 19'd524287, 21'd524287};
    vecs[5]  = '{8'd0,   19'd524287, 21'd0};
    vecs[6]  = '{8'd37,  19'd0,      21'd0};
    vecs[7]  = '{8'd99,  19'd100,    21'd99};
`ifdef CALC_VALUE_CLAMP_EN
    vecs[8]  = '{8'd200, 19'd1000,   21'd1000};
    vecs[9]  = '{8'd255, 19'd524287, 21'd524287};
    vecs[10] = '{8'd101, 19'd100,    21'd100};
`else
    vecs[8]  = '{8'd200, 19'd1000,   21'd2000};
    vecs[9]  = '{8'd255, 19'd524287, 21'd1336932};
    vecs[10] = '{8'd101, 19'd100,    21'd101};
`endif

    // Reset state; start is held high to show it has no effect in reset.
    reset = 1'b0; start = 1'b1; percent = 8'd50; full_scale = 19'd1000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_value", value, 0);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Table-driven directed vectors.
    for (int i = 0; i < 11; i++) begin
      do_calc(vecs[i].p, vecs[i].fs, got, lat);
      check($sformatf("vec%0d_value", i), got, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, LATENCY);
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [7:0]       rp;
      logic [NUM_W-1:0] rfs;
      rp  = 8'($urandom_range(0, 255));
      rfs = (i % 6 == 0) ? {NUM_W{1'b1}} : NUM_W'($urandom);
      do_calc(rp, rfs, got, lat);
      check($sformatf("rand%0d_value", i), got, model(int'(rp), longint'(rfs)));
      check($sformatf("rand%0d_latency", i), lat, LATENCY);
    end

    // Operand changes and a second start while busy are ignored.
    @(negedge clk);
    start = 1'b1; percent = 8'd50; full_scale = 19'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 0; first_rise = -1; prev_done = done;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin
        percent = 8'd99; full_scale = 19'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done && !prev_done) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev_done = done;
    end
    $display("txn busy-start ignored: value=%0d rises=%0d", value, rises);
    check("busy_ignore_value",  value, 500);
    check("busy_ignore_rises",  rises, 1);
    check("busy_ignore_lat",    first_rise, LATENCY);
    check("done_held",          done, 1);

    // New start: done drops, old value stays; start held high restarts.
    @(negedge clk);
    start = 1'b1; percent = 8'd25; full_scale = 19'd400;
    @(posedge clk); #1;
    check("restart_done_drop", done, 0);
    check("restart_old_value", value, 500);
    wait_done(lat);
    $display("txn held-start first: value=%0d latency=%0d", value, lat);
    check("held_value", value, 100);
    check("held_latency", lat, LATENCY);
    @(posedge clk); #1;
    check("held_restart_done", done, 0);
    check("held_restart_busy", busy, 1);
    start = 1'b0;
    wait_done(lat);
    $display("txn held-start second: value=%0d latency=%0d", value, lat);
    check("held_second_value", value, 100);
    check("held_second_latency", lat, LATENCY);

    // Reset in the middle of a computation.
    @(negedge clk);
    start = 1'b1; percent = 8'd50; full_scale = 19'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("midreset_busy",  busy,  0);
    check("midreset_done",  done,  0);
    check("midreset_value", value, 0);
    repeat (30) @(posedge clk);
    #1;
    check("midreset_no_done", done, 0);
    // Start presented together with release is taken on the first edge.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; percent = 8'd25; full_scale = 19'd400;
    @(posedge clk); #1;
    start = 1'b0;
    check("release_busy", busy, 1);
    wait_done(lat);
    $display("txn after reset: value=%0d latency=%0d", value, lat);
    check("release_value", value, 100);
    check("release_latency", lat, LATENCY);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
